// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: EX-stage control-flow sequencer. Gates comparator
// results on operand readiness, stalls across load-use dependencies, flushes
// younger stages on taken branches/jumps and holds a redirect request to
// fetch until it is accepted. Also keeps saturating branch/taken counters.
module branch_redirect_ctrl #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] RESET_PC = 32'h00400004
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic [3:0]       ex_br,
    input  logic             ex_load_dep,
    input  logic             cmp_success,
    input  logic [31:0]      cmp_target,
    input  logic             fetch_ready,
    output logic             stall_pipe,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             misalign_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_OP  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        br_ev;
    logic        is_jump;
    logic        taken;
    logic        misaligned;
    logic [31:0] eff_target;

    // One-cycle strobes produced by the FSM in the resolve cycle
    logic        count_go;
    logic        redirect_go;
    logic        misalign_go;

    // Saturating increment: counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&v) ? v : v + one;
    endfunction

    // Decode the EX branch code, effective target and alignment check
    always_comb begin
        br_ev      = ex_valid && (ex_br >= 4'd1) && (ex_br <= 4'd8);
        is_jump    = (ex_br == 4'd7) || (ex_br == 4'd8);
        // Jumps are unconditional; conditional branches follow the comparator
        taken      = cmp_success || is_jump;
        eff_target = (ex_br == 4'd8) ? {cmp_target[31:1], 1'b0} : cmp_target;
        // JALR already has bit 0 cleared, so only bit 1 can fault it
        misaligned = eff_target[1] || ((ex_br != 4'd8) && eff_target[0]);
    end

    // FSM next-state and combinational pipeline controls
    always_comb begin
        state_nxt      = state;
        stall_pipe     = 1'b0;
        flush_ifid     = 1'b0;
        flush_idex     = 1'b0;
        redirect_valid = 1'b0;
        count_go       = 1'b0;
        redirect_go    = 1'b0;
        misalign_go    = 1'b0;
        case (state)
            RUN, WAIT_OP: begin
                if (br_ev && ex_load_dep) begin
                    stall_pipe = 1'b1;
                    state_nxt  = WAIT_OP;
                end else if (br_ev) begin
                    count_go  = 1'b1;
                    state_nxt = RUN;
                    if (taken && misaligned) begin
                        misalign_go = 1'b1;
                    end else if (taken) begin
                        flush_ifid  = 1'b1;
                        flush_idex  = 1'b1;
                        redirect_go = 1'b1;
                        state_nxt   = REDIRECT;
                    end
                end else begin
                    // A dependent branch that vanished was killed upstream
                    state_nxt = RUN;
                end
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                stall_pipe     = 1'b1;
                flush_ifid     = 1'b1;
                if (fetch_ready) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Redirect target, error pulse and statistics counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_pc  <= RESET_PC;
            misalign_err <= 1'b0;
            branch_cnt   <= '0;
            taken_cnt    <= '0;
        end else begin
            misalign_err <= misalign_go;
            if (redirect_go) begin
                redirect_pc <= eff_target;
                taken_cnt   <= sat_inc(taken_cnt);
            end
            if (count_go) begin
                branch_cnt <= sat_inc(branch_cnt);
            end
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed testbench for branch_redirect_ctrl. A second instance with 3-bit
// counters shares the stimulus so counter saturation is reachable quickly.
module tb_branch_redirect_ctrl;

    localparam logic [31:0] RESET_PC = 32'h00400004;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic [3:0]  ex_br;
    logic        ex_load_dep;
    logic        cmp_success;
    logic [31:0] cmp_target;
    logic        fetch_ready;

    logic        stall_pipe, flush_ifid, flush_idex, redirect_valid, misalign_err;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt, taken_cnt;

    logic        s_stall, s_fi, s_fx, s_rv, s_mis;
    logic [31:0] s_pc;
    logic [2:0]  s_branch_cnt, s_taken_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_br  = 0;
    int exp_tk  = 0;

    branch_redirect_ctrl #(.CNT_W(16), .RESET_PC(RESET_PC)) u_dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_br(ex_br),
        .ex_load_dep(ex_load_dep), .cmp_success(cmp_success),
        .cmp_target(cmp_target), .fetch_ready(fetch_ready),
        .stall_pipe(stall_pipe), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .misalign_err(misalign_err), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    branch_redirect_ctrl #(.CNT_W(3), .RESET_PC(RESET_PC)) u_small (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_br(ex_br),
        .ex_load_dep(ex_load_dep), .cmp_success(cmp_success),
        .cmp_target(cmp_target), .fetch_ready(fetch_ready),
        .stall_pipe(s_stall), .flush_ifid(s_fi), .flush_idex(s_fx),
        .redirect_valid(s_rv), .redirect_pc(s_pc),
        .misalign_err(s_mis), .branch_cnt(s_branch_cnt), .taken_cnt(s_taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic s, input logic fi,
                            input logic fx, input logic rv);
        chk({tag, ".stall"}, {31'd0, stall_pipe}, {31'd0, s});
        chk({tag, ".flush_ifid"}, {31'd0, flush_ifid}, {31'd0, fi});
        chk({tag, ".flush_idex"}, {31'd0, flush_idex}, {31'd0, fx});
        chk({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, rv});
    endtask

    function automatic int sat7(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    task automatic chk_cnt(input string tag);
        chk({tag, ".branch_cnt"}, {16'd0, branch_cnt}, exp_br);
        chk({tag, ".taken_cnt"}, {16'd0, taken_cnt}, exp_tk);
        chk({tag, ".small_branch_cnt"}, {29'd0, s_branch_cnt}, sat7(exp_br));
        chk({tag, ".small_taken_cnt"}, {29'd0, s_taken_cnt}, sat7(exp_tk));
    endtask

    task automatic set_in(input logic v, input logic [3:0] br, input logic dep,
                          input logic s, input logic [31:0] t, input logic fr);
        ex_valid    = v;
        ex_br       = br;
        ex_load_dep = dep;
        cmp_success = s;
        cmp_target  = t;
        fetch_ready = fr;
    endtask

    task automatic idle(input logic fr);
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 32'h0, fr);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle(1'b1);
        @(negedge clk);
        chk_ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.pc", redirect_pc, RESET_PC);
        chk("reset.misalign", {31'd0, misalign_err}, 32'd0);
        chk_cnt("reset");
        tick;
        reset = 1'b0;

        // BEQ not taken
        set_in(1'b1, 4'd1, 1'b0, 1'b0, 32'h00400010, 1'b1);
        @(negedge clk);
        chk_ctrl("beq_nt", 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        exp_br = 1;
        chk_cnt("beq_nt");
        chk("beq_nt.misalign", {31'd0, misalign_err}, 32'd0);

        // BNE taken, fetch ready immediately
        set_in(1'b1, 4'd2, 1'b0, 1'b1, 32'h00400040, 1'b1);
        @(negedge clk);
        chk_ctrl("bne_res", 1'b0, 1'b1, 1'b1, 1'b0);
        tick;
        exp_br = 2; exp_tk = 1;
        idle(1'b1);
        @(negedge clk);
        chk_ctrl("bne_redir", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("bne_redir.pc", redirect_pc, 32'h00400040);
        chk_cnt("bne_redir");
        tick;
        @(negedge clk);
        chk_ctrl("bne_after", 1'b0, 1'b0, 1'b0, 1'b0);
        tick;

        // JAL taken, fetch stalls 3 cycles; EX garbage must be ignored
        set_in(1'b1, 4'd7, 1'b0, 1'b0, 32'h00400080, 1'b0);
        @(negedge clk);
        chk_ctrl("jal_res", 1'b0, 1'b1, 1'b1, 1'b0);
        tick;
        exp_br = 3; exp_tk = 2;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 4'd2, 1'b0, 1'b1, 32'h00400800, (i == 3));
            @(negedge clk);
            chk_ctrl($sformatf("jal_hold%0d", i), 1'b1, 1'b1, 1'b0, 1'b1);
            chk($sformatf("jal_hold%0d.pc", i), redirect_pc, 32'h00400080);
            tick;
        end
        chk_cnt("jal_hold");
        idle(1'b1);
        @(negedge clk);
        chk_ctrl("jal_after", 1'b0, 1'b0, 1'b0, 1'b0);
        tick;

        // BLT with 2 cycles of load-use stall
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 4'd3, 1'b1, 1'b0, 32'h00400100, 1'b1);
            @(negedge clk);
            chk_ctrl($sformatf("blt_stall%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick;
            chk_cnt($sformatf("blt_stall%0d", i));
        end
        set_in(1'b1, 4'd3, 1'b0, 1'b1, 32'h00400100, 1'b1);
        @(negedge clk);
        chk_ctrl("blt_res", 1'b0, 1'b1, 1'b1, 1'b0);
        tick;
        exp_br = 4; exp_tk = 3;
        chk_cnt("blt_res");
        idle(1'b1);
        @(negedge clk);
        chk_ctrl("blt_redir", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("blt_redir.pc", redirect_pc, 32'h00400100);
        tick;

        // BGE waiting on a load, then killed
        set_in(1'b1, 4'd4, 1'b1, 1'b1, 32'h00400200, 1'b1);
        @(negedge clk);
        chk_ctrl("kill_stall", 1'b1, 1'b0, 1'b0, 1'b0);
        tick;
        idle(1'b1);
        @(negedge clk);
        chk_ctrl("kill_drop", 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        chk_cnt("kill_drop");

        // Illegal code with ex_valid is not a branch
        set_in(1'b1, 4'd9, 1'b0, 1'b1, 32'h00400300, 1'b1);
        @(negedge clk);
        chk_ctrl("illegal", 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        chk_cnt("illegal");

        // JALR clears bit 0 of the target
        set_in(1'b1, 4'd8, 1'b0, 1'b1, 32'h00400041, 1'b1);
        @(negedge clk);
        chk_ctrl("jalr_res", 1'b0, 1'b1, 1'b1, 1'b0);
        tick;
        exp_br = 5; exp_tk = 4;
        idle(1'b1);
        @(negedge clk);
        chk("jalr.pc", redirect_pc, 32'h00400040);
        chk_ctrl("jalr_redir", 1'b1, 1'b1, 1'b0, 1'b1);
        tick;

        // JAL to a misaligned target
        set_in(1'b1, 4'd7, 1'b0, 1'b1, 32'h00400042, 1'b1);
        @(negedge clk);
        chk_ctrl("mis_jal_res", 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        exp_br = 6;
        chk("mis_jal.err", {31'd0, misalign_err}, 32'd1);
        chk_cnt("mis_jal");
        idle(1'b1);
        @(negedge clk);
        chk_ctrl("mis_jal_next", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mis_jal.pc", redirect_pc, 32'h00400040);
        tick;
        chk("mis_jal.err_clr", {31'd0, misalign_err}, 32'd0);

        // BEQ taken with bit 0 set is misaligned
        set_in(1'b1, 4'd1, 1'b0, 1'b1, 32'h00400041, 1'b1);
        @(negedge clk);
        chk_ctrl("mis_beq_res", 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        exp_br = 7;
        chk("mis_beq.err", {31'd0, misalign_err}, 32'd1);

        // Drive the small instance into saturation
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 4'd2, 1'b0, 1'b1, 32'h00400400 + 32'(i * 4), 1'b1);
            tick;
            idle(1'b1);
            tick;
        end
        exp_br = 12; exp_tk = 9;
        chk_cnt("sat_taken");
        chk("sat.pc", redirect_pc, 32'h00400410);
        set_in(1'b1, 4'd5, 1'b0, 1'b0, 32'h00400500, 1'b1);
        tick;
        set_in(1'b1, 4'd6, 1'b0, 1'b0, 32'h00400500, 1'b1);
        tick;
        exp_br = 14;
        chk_cnt("sat_nt");

        // Reset in the middle of REDIRECT
        idle(1'b1);
        tick;
        set_in(1'b1, 4'd2, 1'b0, 1'b1, 32'h00400600, 1'b0);
        tick;
        idle(1'b0);
        @(negedge clk);
        chk_ctrl("rst_pre", 1'b1, 1'b1, 1'b0, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk_ctrl("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid.pc", redirect_pc, RESET_PC);
        exp_br = 0; exp_tk = 0;
        chk_cnt("rst_mid");
        #1 reset = 1'b0;
        tick;
        @(negedge clk);
        chk_ctrl("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        set_in(1'b1, 4'd2, 1'b0, 1'b1, 32'h00400700, 1'b1);
        @(negedge clk);
        chk_ctrl("rst_next_res", 1'b0, 1'b1, 1'b1, 1'b0);
        tick;
        exp_br = 1; exp_tk = 1;
        idle(1'b1);
        @(negedge clk);
        chk_ctrl("rst_next_redir", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("rst_next.pc", redirect_pc, 32'h00400700);
        chk_cnt("rst_next");
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
